// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg : shared sizing helpers and saturation bounds for the accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Wide enough for the full channel sum plus bias without overflow.
   function automatic int acc_w(input int in_w, input int num_ch, input int out_w);
      return max_int(in_w + clog2(num_ch), out_w) + 1;
   endfunction

   function automatic longint sat_max(input int out_w);
      return (longint'(1) <<< (out_w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int out_w);
      return -(longint'(1) <<< (out_w - 1));
   endfunction

   // Operand count at tree level lvl (level 0 is the raw channels).
   function automatic int tree_n(input int num_ch, input int lvl);
      int n;
      n = num_ch;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

   // Operand offset of level lvl inside the flattened all-levels tree bus.
   function automatic int tree_off(input int num_ch, input int lvl);
      int s;
      s = 0;
      for (int i = 0; i < lvl; i++) s = s + tree_n(num_ch, i);
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/conv_channel_accumulator_if.sv
// ============================================================================
// conv_channel_accumulator_if : input beat / output stream bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface conv_channel_accumulator_if #(
   parameter int NUM_CH    = 3,
   parameter int IN_WIDTH  = 20,
   parameter int OUT_WIDTH = 22
);
   logic                          clear;
   logic                          in_valid;
   logic                          in_ready;
   logic [NUM_CH*IN_WIDTH-1:0]    in_data;
   logic [OUT_WIDTH-1:0]          bias;
   logic                          relu_en;
   logic                          out_valid;
   logic                          out_ready;
   logic [OUT_WIDTH-1:0]          out_data;
   logic                          out_last;
   logic                          sat_flag;

   modport master (
      output clear, in_valid, in_data, bias, relu_en, out_ready,
      input  in_ready, out_valid, out_data, out_last, sat_flag
   );

   modport slave (
      input  clear, in_valid, in_data, bias, relu_en, out_ready,
      output in_ready, out_valid, out_data, out_last, sat_flag
   );
endinterface

`default_nettype wire

// File: rtl/conv_adder_tree_stage.sv
// ============================================================================
// conv_adder_tree_stage : one registered pairwise-add level with sideband
// Rev 1.0
// ============================================================================
`default_nettype none

module conv_adder_tree_stage #(
   parameter  int N_IN   = 3,
   parameter  int W      = 23,
   parameter  int SIDE_W = 23,
   localparam int N_OUT  = (N_IN + 1) / 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic [N_IN*W-1:0]    in_data,
   input  logic [SIDE_W-1:0]    in_side,
   output logic                 out_valid,
   output logic [N_OUT*W-1:0]   out_data,
   output logic [SIDE_W-1:0]    out_side
);
   logic [N_OUT*W-1:0] w_sum;
   logic               r_valid;
   logic [N_OUT*W-1:0] r_data;
   logic [SIDE_W-1:0]  r_side;

   for (genvar j = 0; j < N_OUT; j++) begin : g_pair
      if (2*j + 1 < N_IN) begin : g_add
         assign w_sum[j*W +: W] = in_data[2*j*W +: W] + in_data[(2*j+1)*W +: W];
      end else begin : g_pass
         // Odd leftover operand rides through so every level has equal latency.
         assign w_sum[j*W +: W] = in_data[2*j*W +: W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_side  <= '0;
      end else if (clear) begin
         r_valid <= 1'b0;
      end else if (en) begin
         r_valid <= in_valid;
         r_data  <= w_sum;
         r_side  <= in_side;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_side  = r_side;
endmodule

`default_nettype wire

// File: rtl/conv_channel_accumulator.sv
// ============================================================================
// conv_channel_accumulator : cross-channel adder tree + bias/ReLU/saturate
// Rev 1.0
// ============================================================================
`default_nettype none

module conv_channel_accumulator
   import conv_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int IN_WIDTH    = 20,
   parameter int OUT_WIDTH   = 22,
   parameter int NUM_WINDOWS = 4096
)(
   input  logic                         clk,
   input  logic                         rst,
   conv_channel_accumulator_if.slave    bus
);
   localparam int c_acc_w  = acc_w(IN_WIDTH, NUM_CH, OUT_WIDTH);
   localparam int c_t      = clog2(NUM_CH);
   localparam int c_side_w = OUT_WIDTH + 1;
   localparam int c_tree_w = tree_off(NUM_CH, c_t + 1) * c_acc_w;
   localparam int c_cnt_w  = (NUM_WINDOWS > 1) ? clog2(NUM_WINDOWS) : 1;

   localparam logic signed [c_acc_w-1:0] c_sat_max = c_acc_w'(sat_max(OUT_WIDTH));
   localparam logic signed [c_acc_w-1:0] c_sat_min = c_acc_w'(sat_min(OUT_WIDTH));
   localparam logic [c_cnt_w-1:0]        c_win_last = c_cnt_w'(NUM_WINDOWS - 1);

   logic                      w_adv;
   logic [c_tree_w-1:0]       w_tree;
   logic                      w_lvl_valid [0:c_t];
   logic [c_side_w-1:0]       w_lvl_side  [0:c_t];

   logic signed [c_acc_w-1:0] w_sum;
   logic signed [c_acc_w-1:0] w_bias_ext;
   logic signed [c_acc_w-1:0] w_total;
   logic signed [c_acc_w-1:0] w_relu;
   logic [OUT_WIDTH-1:0]      w_sat;
   logic                      w_clip;
   logic                      w_relu_en;
   logic [OUT_WIDTH-1:0]      w_bias;

   logic                      r_out_valid;
   logic [OUT_WIDTH-1:0]      r_out_data;
   logic                      r_sat_flag;
   logic [c_cnt_w-1:0]        r_win_cnt;

   // Global stall: the whole pipeline moves only when the output slot frees up.
   assign w_adv = !r_out_valid || bus.out_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      assign w_tree[k*c_acc_w +: c_acc_w] =
         {{(c_acc_w-IN_WIDTH){bus.in_data[k*IN_WIDTH + IN_WIDTH - 1]}},
          bus.in_data[k*IN_WIDTH +: IN_WIDTH]};
   end

   assign w_lvl_valid[0] = bus.in_valid;
   assign w_lvl_side[0]  = {bus.relu_en, bus.bias};

   for (genvar l = 0; l < c_t; l++) begin : g_level
      localparam int c_n_in    = tree_n(NUM_CH, l);
      localparam int c_n_out   = tree_n(NUM_CH, l + 1);
      localparam int c_off_in  = tree_off(NUM_CH, l) * c_acc_w;
      localparam int c_off_out = tree_off(NUM_CH, l + 1) * c_acc_w;

      conv_adder_tree_stage #(
         .N_IN   (c_n_in),
         .W      (c_acc_w),
         .SIDE_W (c_side_w)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .clear     (bus.clear),
         .en        (w_adv),
         .in_valid  (w_lvl_valid[l]),
         .in_data   (w_tree[c_off_in +: c_n_in*c_acc_w]),
         .in_side   (w_lvl_side[l]),
         .out_valid (w_lvl_valid[l+1]),
         .out_data  (w_tree[c_off_out +: c_n_out*c_acc_w]),
         .out_side  (w_lvl_side[l+1])
      );
   end

   assign w_sum     = w_tree[tree_off(NUM_CH, c_t)*c_acc_w +: c_acc_w];
   assign w_relu_en = w_lvl_side[c_t][OUT_WIDTH];
   assign w_bias    = w_lvl_side[c_t][OUT_WIDTH-1:0];

   always_comb begin
      w_bias_ext = {{(c_acc_w-OUT_WIDTH){w_bias[OUT_WIDTH-1]}}, w_bias};
      w_total    = w_sum + w_bias_ext;
      w_relu     = (w_relu_en && w_total[c_acc_w-1]) ? '0 : w_total;
      w_clip     = 1'b0;
      w_sat      = w_relu[OUT_WIDTH-1:0];
      if (w_relu > c_sat_max) begin
         w_sat  = c_sat_max[OUT_WIDTH-1:0];
         w_clip = 1'b1;
      end else if (w_relu < c_sat_min) begin
         w_sat  = c_sat_min[OUT_WIDTH-1:0];
         w_clip = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_sat_flag  <= 1'b0;
         r_win_cnt   <= '0;
      end else if (bus.clear) begin
         r_out_valid <= 1'b0;
         r_sat_flag  <= 1'b0;
         r_win_cnt   <= '0;
      end else begin
         if (w_adv) begin
            r_out_valid <= w_lvl_valid[c_t];
            if (w_lvl_valid[c_t]) begin
               r_out_data <= w_sat;
               if (w_clip) r_sat_flag <= 1'b1;
            end
         end
         if (r_out_valid && bus.out_ready) begin
            r_win_cnt <= (r_win_cnt == c_win_last) ? '0 : r_win_cnt + 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_valid && (r_win_cnt == c_win_last);
   assign bus.sat_flag  = r_sat_flag;
endmodule

`default_nettype wire
